// File: rtl/wb_chan_fanout.sv
// wb_chan_fanout
//   Wishbone fan-out from one upstream target port to NCHAN downstream
//   channel ports. A field of the upstream address selects the channel,
//   and only that channel sees cyc/stb. One transfer is in flight at a
//   time, with a per-transfer timeout. Unmapped channels and timeouts
//   answer with err. A saturating counter counts every err returned
//   upstream.
//
// Ports
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   wb_cyc_i .. wb_sel_i upstream request (cyc, stb, we, adr, dat, sel)
//   wb_ack_o/err_o/rty_o registered upstream response, one cycle, exclusive
//   wb_dat_o             upstream read data (0 on err)
//   m_cyc_o, m_stb_o     per-channel cycle/strobe, one-hot or zero
//   m_we_o .. m_sel_o    shared registered downstream request fields
//   m_ack_i/err_i/rty_i  per-channel responses
//   m_dat_i              per-channel read data, channel k at [k*DW +: DW]
//   err_count_o          saturating count of upstream err responses
module wb_chan_fanout #(
  parameter int NCHAN    = 8,
  parameter int AW       = 22,
  parameter int DW       = 32,
  parameter int LOCAL_AW = 8,
  parameter int SEL_LSB  = 8,
  parameter int SEL_W    = 3,
  parameter int TIMEOUT  = 255,
  parameter int ERRCNT_W = 16,
  localparam int SW      = DW / 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [AW-1:0]       wb_adr_i,
  input  logic [DW-1:0]       wb_dat_i,
  input  logic [SW-1:0]       wb_sel_i,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_rty_o,
  output logic [DW-1:0]       wb_dat_o,
  output logic [NCHAN-1:0]    m_cyc_o,
  output logic [NCHAN-1:0]    m_stb_o,
  output logic                m_we_o,
  output logic [LOCAL_AW-1:0] m_adr_o,
  output logic [DW-1:0]       m_dat_o,
  output logic [SW-1:0]       m_sel_o,
  input  logic [NCHAN-1:0]    m_ack_i,
  input  logic [NCHAN-1:0]    m_err_i,
  input  logic [NCHAN-1:0]    m_rty_i,
  input  logic [NCHAN*DW-1:0] m_dat_i,
  output logic [ERRCNT_W-1:0] err_count_o
);

  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  logic [SEL_W-1:0]     idx;
  logic [SEL_W-1:0]     sel_field;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 tmo_hit;
  logic                 resp_ack;
  logic                 resp_err;
  logic                 resp_rty;
  logic [DW-1:0]        resp_dat;
  logic [ERRCNT_W-1:0]  err_count_inc;
  logic                 unused_adr;

  assign sel_field = wb_adr_i[SEL_LSB +: SEL_W];

  // Address bits outside the forwarded and select fields are ignored.
  assign unused_adr = ^wb_adr_i;

  // Per-channel strobe always mirrors the per-channel cycle.
  assign m_stb_o = m_cyc_o;

  // The timeout counter starts at 0 on BUSY entry, so hitting TIMEOUT-1
  // means TIMEOUT BUSY cycles have elapsed without a response.
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_W'(TIMEOUT - 1));

  assign err_count_inc = (err_count_o == '1) ? err_count_o : err_count_o + 1'b1;

  // Only the latched channel can respond; the other channels are masked out.
  always_comb begin
    resp_ack = 1'b0;
    resp_err = 1'b0;
    resp_rty = 1'b0;
    resp_dat = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (idx == SEL_W'(k)) begin
        resp_ack = m_ack_i[k];
        resp_err = m_err_i[k];
        resp_rty = m_rty_i[k];
        resp_dat = m_dat_i[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      idx         <= '0;
      tmo_cnt     <= '0;
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      wb_rty_o    <= 1'b0;
      wb_dat_o    <= '0;
      m_cyc_o     <= '0;
      m_we_o      <= 1'b0;
      m_adr_o     <= '0;
      m_dat_o     <= '0;
      m_sel_o     <= '0;
      err_count_o <= '0;
    end else begin
      // Upstream response lasts exactly one cycle (the DONE state).
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_rty_o <= 1'b0;
      wb_dat_o <= '0;
      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            if (int'(sel_field) >= NCHAN) begin
              wb_err_o    <= 1'b1;
              err_count_o <= err_count_inc;
              state       <= DONE;
            end else begin
              idx     <= sel_field;
              m_we_o  <= wb_we_i;
              m_adr_o <= wb_adr_i[LOCAL_AW-1:0];
              m_dat_o <= wb_dat_i;
              m_sel_o <= wb_sel_i;
              m_cyc_o <= NCHAN'(1) << sel_field;
              tmo_cnt <= '0;
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          // An upstream abort wins over any response arriving in the same
          // cycle: the master is gone, so nothing is returned.
          if (!wb_cyc_i) begin
            m_cyc_o <= '0;
            state   <= IDLE;
          end else if (resp_err || resp_rty || resp_ack) begin
            m_cyc_o <= '0;
            state   <= DONE;
            if (resp_err) begin
              wb_err_o    <= 1'b1;
              err_count_o <= err_count_inc;
            end else if (resp_rty) begin
              wb_rty_o <= 1'b1;
              wb_dat_o <= resp_dat;
            end else begin
              wb_ack_o <= 1'b1;
              wb_dat_o <= resp_dat;
            end
          end else if (tmo_hit) begin
            m_cyc_o     <= '0;
            wb_err_o    <= 1'b1;
            err_count_o <= err_count_inc;
            state       <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_chan_fanout.sv
// tb_wb_chan_fanout
//   Self-checking bench for wb_chan_fanout. The main instance uses six
//   channels and a 16-cycle timeout; a second instance sharing all inputs
//   has a 2-bit error counter so its saturation can be observed.
//   Expected cycle timing, channel selection and responses come from a
//   transaction-level model of the block's rules inside run_xfer.
module tb_wb_chan_fanout;

  localparam int NCH = 6;
  localparam int AW  = 22;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int LAW = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            cyc, stb, we;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   wdat;
  logic [SW-1:0]   sel;
  logic            ack, err, rty;
  logic [DW-1:0]   rdat;
  logic [NCH-1:0]  m_cyc, m_stb;
  logic            m_we;
  logic [LAW-1:0]  m_adr;
  logic [DW-1:0]   m_dat;
  logic [SW-1:0]   m_sel;
  logic [NCH-1:0]  s_ack, s_err, s_rty;
  logic [NCH*DW-1:0] s_dat;
  logic [15:0]     errcnt;

  logic            s2_ack, s2_err, s2_rty;
  logic [DW-1:0]   s2_rdat;
  logic [NCH-1:0]  s2_cyc, s2_stb;
  logic            s2_we;
  logic [LAW-1:0]  s2_adr;
  logic [DW-1:0]   s2_dat;
  logic [SW-1:0]   s2_sel;
  logic [1:0]      s2_errcnt;

  int vectors     = 0;
  int miscompares = 0;
  int exp_errcnt  = 0;

  wb_chan_fanout #(
    .NCHAN(NCH), .AW(AW), .DW(DW), .LOCAL_AW(LAW), .SEL_LSB(8), .SEL_W(3),
    .TIMEOUT(TMO), .ERRCNT_W(16)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .wb_dat_o(rdat),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_adr_o(m_adr),
    .m_dat_o(m_dat), .m_sel_o(m_sel), .m_ack_i(s_ack), .m_err_i(s_err),
    .m_rty_i(s_rty), .m_dat_i(s_dat), .err_count_o(errcnt)
  );

  wb_chan_fanout #(
    .NCHAN(NCH), .AW(AW), .DW(DW), .LOCAL_AW(LAW), .SEL_LSB(8), .SEL_W(3),
    .TIMEOUT(TMO), .ERRCNT_W(2)
  ) dut_sat (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_ack_o(s2_ack), .wb_err_o(s2_err), .wb_rty_o(s2_rty), .wb_dat_o(s2_rdat),
    .m_cyc_o(s2_cyc), .m_stb_o(s2_stb), .m_we_o(s2_we), .m_adr_o(s2_adr),
    .m_dat_o(s2_dat), .m_sel_o(s2_sel), .m_ack_i(s_ack), .m_err_i(s_err),
    .m_rty_i(s_rty), .m_dat_i(s_dat), .err_count_o(s2_errcnt)
  );

  // Downstream channels: random chatter on every channel except the one
  // being addressed, which answers only when told to.
  task automatic drive_slaves(input logic [NCH-1:0] mask, input int ch, input bit respond,
                              input logic [2:0] kind, input logic [DW-1:0] rd);
    s_ack = NCH'($urandom) & ~mask;
    s_err = NCH'($urandom) & ~mask;
    s_rty = NCH'($urandom) & ~mask;
    for (int k = 0; k < NCH; k++) s_dat[k*DW +: DW] = $urandom;
    if (respond) begin
      s_ack[ch] = kind[0];
      s_rty[ch] = kind[1];
      s_err[ch] = kind[2];
      s_dat[ch*DW +: DW] = rd;
    end
  endtask

  task automatic clear_slaves();
    s_ack = '0;
    s_err = '0;
    s_rty = '0;
    s_dat = '0;
  endtask

  // One upstream transfer. kind = {err,rty,ack} driven by the selected
  // channel dly cycles after its strobe first appears (0 = silent).
  // base is the cycle in which the strobe is expected: 1 from IDLE, 2 when
  // issued during the previous transfer's DONE cycle.
  task automatic run_xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                          input logic [SW-1:0] bs, input int dly, input logic [2:0] kind,
                          input logic [DW-1:0] rd, input bit idle_first, input int base);
    int ch;
    bit mapped;
    int resp_cyc;
    logic [2:0] exp_resp;
    logic [2:0] exp_flags;
    logic [NCH-1:0] onehot;
    logic [NCH-1:0] exp_cyc;
    logic [DW-1:0] exp_dat;
    int exp_sat;
    bit done;
    ch = (int'(a) >> 8) % 8;
    mapped = (ch < NCH);
    onehot = '0;
    if (mapped) onehot[ch] = 1'b1;
    if (!mapped) begin
      resp_cyc = base;
      exp_resp = 3'b010;
    end else if (kind == 3'b000) begin
      resp_cyc = base + TMO;
      exp_resp = 3'b010;
    end else begin
      resp_cyc = base + dly + 1;
      exp_resp = kind[2] ? 3'b010 : (kind[1] ? 3'b001 : 3'b100);
    end
    exp_dat = (exp_resp == 3'b010) ? '0 : rd;
    if (idle_first) begin
      @(posedge clk); #1;
    end
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; wdat = wd; sel = bs;
    drive_slaves(onehot, ch, 1'b0, kind, rd);
    done = 1'b0;
    for (int c = 1; c <= base + TMO + 1 && !done; c++) begin
      @(posedge clk); #1;
      if (c == resp_cyc && exp_resp == 3'b010) exp_errcnt++;
      exp_sat = (exp_errcnt > 3) ? 3 : exp_errcnt;
      exp_cyc = (mapped && c >= base && c < resp_cyc) ? onehot : '0;
      exp_flags = (c == resp_cyc) ? exp_resp : 3'b000;
      vectors++;
      if (m_cyc !== exp_cyc) begin
        miscompares++;
        $display("[TB] FAIL m_cyc_o adr=%h c=%0d got %h expected %h", a, c, m_cyc, exp_cyc);
      end
      vectors++;
      if (m_stb !== exp_cyc) begin
        miscompares++;
        $display("[TB] FAIL m_stb_o adr=%h c=%0d got %h expected %h", a, c, m_stb, exp_cyc);
      end
      vectors++;
      if ({ack, err, rty} !== exp_flags) begin
        miscompares++;
        $display("[TB] FAIL ack/err/rty adr=%h c=%0d got %b expected %b", a, c, {ack, err, rty}, exp_flags);
      end
      vectors++;
      if (errcnt !== 16'(exp_errcnt)) begin
        miscompares++;
        $display("[TB] FAIL err_count_o c=%0d got %0d expected %0d", c, errcnt, exp_errcnt);
      end
      vectors++;
      if (s2_errcnt !== 2'(exp_sat)) begin
        miscompares++;
        $display("[TB] FAIL err_count_sat c=%0d got %0d expected %0d", c, s2_errcnt, exp_sat);
      end
      if (c == resp_cyc) begin
        vectors++;
        if (rdat !== exp_dat) begin
          miscompares++;
          $display("[TB] FAIL wb_dat_o adr=%h got %h expected %h", a, rdat, exp_dat);
        end
      end
      if (mapped && c == base) begin
        vectors++;
        if ({m_we, m_adr, m_dat, m_sel} !== {w, a[LAW-1:0], wd, bs}) begin
          miscompares++;
          $display("[TB] FAIL m_req_fields got we=%b adr=%h dat=%h sel=%h expected we=%b adr=%h dat=%h sel=%h",
                   m_we, m_adr, m_dat, m_sel, w, a[LAW-1:0], wd, bs);
        end
      end
      if (c == resp_cyc) begin
        cyc = 1'b0; stb = 1'b0;
        clear_slaves();
        done = 1'b1;
      end else begin
        drive_slaves(onehot, ch, mapped && kind != 3'b000 && c == base + dly, kind, rd);
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    vectors++;
    if ({m_cyc, ack, err, rty} !== '0) begin
      miscompares++;
      $display("[TB] FAIL %s got m_cyc=%h ack/err/rty=%b expected all 0", tag, m_cyc, {ack, err, rty});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_errcnt = 0;
    vectors++;
    if ({ack, err, rty, rdat, m_cyc, m_stb, m_we, m_adr, m_dat, m_sel, errcnt, s2_errcnt} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got cyc=%h adr=%h dat=%h cnt=%0d expected all 0", m_cyc, m_adr, m_dat, errcnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_write();
    run_xfer(22'h000310, 1'b1, 32'hDEADBEEF, 4'hF, 2, 3'b001, 32'h0, 1'b1, 1);
  endtask

  task automatic test_read();
    run_xfer(22'h0005A4, 1'b0, 32'h0, 4'hF, 1, 3'b001, 32'h12345678, 1'b1, 1);
    run_xfer(22'h000000, 1'b0, 32'h0, 4'h3, 0, 3'b001, 32'hA5A5_0001, 1'b1, 1);
    run_xfer(22'h3FF5FF, 1'b1, 32'hCAFE_F00D, 4'h8, 4, 3'b001, 32'h0, 1'b1, 1);
  endtask

  task automatic test_decode_err();
    run_xfer(22'h000700, 1'b0, 32'h0, 4'hF, 0, 3'b001, 32'h1, 1'b1, 1);
    run_xfer(22'h000600, 1'b1, 32'h5, 4'hF, 0, 3'b001, 32'h1, 1'b1, 1);
    run_xfer(22'h3FF7AB, 1'b0, 32'h0, 4'hF, 0, 3'b001, 32'h1, 1'b1, 1);
  endtask

  task automatic test_priority();
    run_xfer(22'h000104, 1'b0, 32'h0, 4'hF, 1, 3'b111, 32'h1111_2222, 1'b1, 1);
    run_xfer(22'h000408, 1'b0, 32'h0, 4'hF, 0, 3'b011, 32'h3333_4444, 1'b1, 1);
    run_xfer(22'h00020C, 1'b0, 32'h0, 4'hF, 3, 3'b110, 32'h5555_6666, 1'b1, 1);
    run_xfer(22'h000510, 1'b0, 32'h0, 4'hF, 2, 3'b010, 32'h7777_8888, 1'b1, 1);
  endtask

  task automatic test_timeout();
    run_xfer(22'h000220, 1'b1, 32'h0BAD_0BAD, 4'hF, 0, 3'b000, 32'h0, 1'b1, 1);
    // A late answer from the timed-out channel must not produce a response.
    for (int i = 0; i < 3; i++) begin
      s_ack = 6'b000100;
      @(posedge clk); #1;
      check_quiet("late_ack_ignored");
    end
    clear_slaves();
  endtask

  task automatic test_back_to_back();
    run_xfer(22'h000111, 1'b1, 32'h0000_0001, 4'h1, 0, 3'b001, 32'h0, 1'b1, 1);
    run_xfer(22'h000222, 1'b0, 32'h0, 4'hF, 1, 3'b001, 32'hBEEF_0002, 1'b0, 2);
    run_xfer(22'h000733, 1'b0, 32'h0, 4'hF, 0, 3'b001, 32'h0, 1'b0, 2);
    run_xfer(22'h000344, 1'b0, 32'h0, 4'hF, 0, 3'b010, 32'hBEEF_0004, 1'b0, 2);
  endtask

  task automatic test_abort();
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = 22'h000123; we = 1'b0; wdat = '0; sel = 4'hF;
    clear_slaves();
    @(posedge clk); #1;
    vectors++;
    if (m_cyc !== 6'b000010) begin
      miscompares++;
      $display("[TB] FAIL abort_busy_cyc got %h expected %h", m_cyc, 6'b000010);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_quiet("abort_quiet");
    end
    run_xfer(22'h000140, 1'b0, 32'h0, 4'hF, 1, 3'b001, 32'h0A0B_0C0D, 1'b0, 1);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = 22'h000455; we = 1'b1; wdat = 32'h1234; sel = 4'hF;
    clear_slaves();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_errcnt = 0;
    check_quiet("reset_mid_quiet");
    vectors++;
    if ({errcnt, s2_errcnt, m_adr} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_regs got cnt=%0d sat=%0d adr=%h expected 0", errcnt, s2_errcnt, m_adr);
    end
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check_quiet("reset_mid_after");
    run_xfer(22'h000466, 1'b0, 32'h0, 4'hF, 0, 3'b001, 32'h6666_0000, 1'b0, 1);
  endtask

  task automatic test_err_sat();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_errcnt = 0;
    for (int i = 0; i < 5; i++) run_xfer(22'h000700 + AW'(i), 1'b0, 32'h0, 4'hF, 0, 3'b001, 32'h0, 1'b1, 1);
  endtask

  task automatic test_random();
    bit b;
    logic [2:0] kind;
    for (int i = 0; i < 40; i++) begin
      b = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      kind = ($urandom_range(0, 7) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      run_xfer(AW'($urandom), 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 5),
               kind, $urandom, b, b ? 1 : 2);
    end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; sel = '0;
    clear_slaves();
    test_reset();
    test_write();
    test_read();
    test_decode_err();
    test_priority();
    test_timeout();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_err_sat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog time limit reached before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

endmodule
